// File: rtl/phy_tx_lane_arbiter.sv
// Burst-based round-robin arbiter that drains four registered-read lane FIFOs
// onto a single byte stream with a fixed two-cycle pop-to-valid latency.
module phy_tx_lane_arbiter #(
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             pause,
  input  logic [3:0]       empty,
  input  logic [7:0]       data_in0,
  input  logic [7:0]       data_in1,
  input  logic [7:0]       data_in2,
  input  logic [7:0]       data_in3,
  output logic [3:0]       pop,
  output logic [7:0]       data_out,
  output logic             valid_out,
  output logic [1:0]       grant_id,
  output logic             active
);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       rr_ptr;
  logic [1:0]       rr_ptr_nxt;
  logic [1:0]       grant_nxt;
  logic [1:0]       pick;
  logic [CNT_W-1:0] burst_cnt;
  logic [CNT_W-1:0] burst_cnt_nxt;
  logic             any_ready;
  logic             pop_now;
  logic             burst_last;
  logic             pop_d;
  logic [1:0]       lane_d;
  logic [7:0]       lane_data;

  // Scan downwards so the lane closest to rr_ptr is the last (winning) assignment.
  always_comb begin
    pick = rr_ptr;
    for (int i = 3; i >= 0; i--) begin
      if (!empty[rr_ptr + 2'(i)]) begin
        pick = rr_ptr + 2'(i);
      end
    end
  end

  assign any_ready  = (empty != 4'hF);
  assign pop_now    = (state == BURST) && enable && !pause && !empty[grant_id];
  assign burst_last = (burst_cnt == CNT_W'(BURST_LEN - 1));
  assign pop        = pop_now ? (4'b0001 << grant_id) : 4'b0000;
  assign active     = (state == BURST);

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant_id;
    burst_cnt_nxt = burst_cnt;
    rr_ptr_nxt    = rr_ptr;
    case (state)
      IDLE: begin
        if (enable && !pause && any_ready) begin
          grant_nxt     = pick;
          burst_cnt_nxt = '0;
          state_nxt     = BURST;
        end
      end
      BURST: begin
        if (pop_now) begin
          burst_cnt_nxt = burst_cnt + CNT_W'(1);
        end
        // pause outranks empty: a paused burst never ends on an empty lane
        if (!enable || (pop_now && burst_last) || (!pause && empty[grant_id])) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = grant_id + 2'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rr_ptr    <= 2'd0;
      burst_cnt <= '0;
      grant_id  <= 2'd0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      burst_cnt <= burst_cnt_nxt;
      grant_id  <= grant_nxt;
    end
  end

  always_comb begin
    case (lane_d)
      2'd0:    lane_data = data_in0;
      2'd1:    lane_data = data_in1;
      2'd2:    lane_data = data_in2;
      default: lane_data = data_in3;
    endcase
  end

  // The FIFO presents read data one cycle after pop, so lane_d remembers whose data arrives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pop_d     <= 1'b0;
      lane_d    <= 2'd0;
      valid_out <= 1'b0;
      data_out  <= 8'h00;
    end else begin
      pop_d     <= pop_now;
      lane_d    <= grant_id;
      valid_out <= pop_d;
      if (pop_d) begin
        data_out <= lane_data;
      end
    end
  end

endmodule

// File: tb/tb_phy_tx_lane_arbiter.sv
// Directed bench for phy_tx_lane_arbiter: dut_a uses BURST_LEN=4, dut_b BURST_LEN=2,
// each fed by its own registered-read FIFO model.
module tb_phy_tx_lane_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       pause;
  logic [3:0] empty_a, empty_b, pop_a, pop_b;
  logic [7:0] data_out_a, data_out_b;
  logic       valid_a, valid_b, active_a, active_b;
  logic [1:0] grant_a, grant_b;
  logic [7:0] rd  [2][4];
  logic [7:0] mem [2][4][16];
  int         wp  [2][4];
  int         rp  [2][4];
  int         checks   = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  phy_tx_lane_arbiter #(.BURST_LEN(4), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .pause(pause), .empty(empty_a),
    .data_in0(rd[0][0]), .data_in1(rd[0][1]), .data_in2(rd[0][2]), .data_in3(rd[0][3]),
    .pop(pop_a), .data_out(data_out_a), .valid_out(valid_a), .grant_id(grant_a),
    .active(active_a)
  );

  phy_tx_lane_arbiter #(.BURST_LEN(2), .CNT_W(8)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .pause(pause), .empty(empty_b),
    .data_in0(rd[1][0]), .data_in1(rd[1][1]), .data_in2(rd[1][2]), .data_in3(rd[1][3]),
    .pop(pop_b), .data_out(data_out_b), .valid_out(valid_b), .grant_id(grant_b),
    .active(active_b)
  );

  always @* begin
    for (int i = 0; i < 4; i++) begin
      empty_a[i] = (wp[0][i] == rp[0][i]);
      empty_b[i] = (wp[1][i] == rp[1][i]);
    end
  end

  // Registered-read FIFOs: data for a pop appears on rd one cycle later.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (pop_a[i]) begin
        rd[0][i] <= mem[0][i][rp[0][i][3:0]];
        rp[0][i] <= rp[0][i] + 1;
      end
      if (pop_b[i]) begin
        rd[1][i] <= mem[1][i][rp[1][i][3:0]];
        rp[1][i] <= rp[1][i] + 1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic pa);
    enable = en;
    pause  = pa;
  endtask

  task automatic loadLane(input int d, input int lane, input int n, input logic [7:0] base);
    for (int k = 0; k < n; k++) begin
      mem[d][lane][wp[d][lane][3:0]] = base + 8'(k);
      wp[d][lane] = wp[d][lane] + 1;
    end
  endtask

  task automatic doReset();
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++) wp[d][i] = rp[d][i];
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [11:0] t1_pop, t1_act, t1_val;
    logic [13:0] t3_pop, t3_act, t3_val;
    int          k;
    int          n;

    reset = 1'b1;
    applyStimulus(1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    checkOutput("rst_pop",   {4'b0, pop_a},    8'h00);
    checkOutput("rst_valid", {7'b0, valid_a},  8'h00);
    checkOutput("rst_data",  data_out_a,       8'h00);
    checkOutput("rst_active",{7'b0, active_a}, 8'h00);
    checkOutput("rst_grant", {6'b0, grant_a},  8'h00);

    $display("[TB] test 1: single lane, two bursts");
    doReset();
    t1_pop = 12'b0000_1101_1110;
    t1_act = 12'b0001_1101_1110;
    t1_val = 12'b0011_0111_1000;
    k = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 0) begin
        loadLane(0, 0, 6, 8'hA0);
        applyStimulus(1'b1, 1'b0);
      end
      #1;
      checkOutput($sformatf("t1_pop_c%0d", c), {4'b0, pop_a}, t1_pop[c] ? 8'h01 : 8'h00);
      checkOutput($sformatf("t1_active_c%0d", c), {7'b0, active_a}, {7'b0, t1_act[c]});
      checkOutput($sformatf("t1_valid_c%0d", c), {7'b0, valid_a}, {7'b0, t1_val[c]});
      if (t1_val[c]) begin
        checkOutput($sformatf("t1_data_c%0d", c), data_out_a, 8'hA0 + 8'(k));
        k++;
      end
    end

    $display("[TB] test 2: four lanes, BURST_LEN=2");
    doReset();
    n = 0;
    for (int c = 0; c < 56; c++) begin
      @(negedge clk);
      if (c == 0) begin
        for (int i = 0; i < 4; i++) loadLane(1, i, 8, 8'(i * 16));
        applyStimulus(1'b1, 1'b0);
      end
      #1;
      if (pop_b != 4'b0000)
        checkOutput($sformatf("t2_pop_legal_c%0d", c),
                    {7'b0, $onehot(pop_b) && ((pop_b & empty_b) == 4'b0000)}, 8'h01);
      if (valid_b) begin
        checkOutput($sformatf("t2_data_n%0d", n), data_out_b,
                    8'(((n / 2) % 4) * 16 + (n / 8) * 2 + (n % 2)));
        checkOutput($sformatf("t2_cycle_n%0d", n), 8'(c), 8'(3 * (n / 2) + 3 + (n % 2)));
        n++;
      end
    end
    checkOutput("t2_byte_count", 8'(n), 8'd32);

    $display("[TB] test 3: pause mid-burst on lane 2");
    doReset();
    t3_pop = 14'b00_0110_1110_0010;
    t3_act = 14'b00_1110_1111_1110;
    t3_val = 14'b01_1011_1000_1000;
    k = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (c == 0) begin
        loadLane(0, 2, 6, 8'hC0);
        applyStimulus(1'b1, 1'b0);
      end
      if (c == 2) applyStimulus(1'b1, 1'b1);
      if (c == 5) applyStimulus(1'b1, 1'b0);
      #1;
      checkOutput($sformatf("t3_pop_c%0d", c), {4'b0, pop_a}, t3_pop[c] ? 8'h04 : 8'h00);
      checkOutput($sformatf("t3_active_c%0d", c), {7'b0, active_a}, {7'b0, t3_act[c]});
      checkOutput($sformatf("t3_valid_c%0d", c), {7'b0, valid_a}, {7'b0, t3_val[c]});
      if (t3_act[c]) checkOutput($sformatf("t3_grant_c%0d", c), {6'b0, grant_a}, 8'h02);
      if (t3_val[c]) begin
        checkOutput($sformatf("t3_data_c%0d", c), data_out_a, 8'hC0 + 8'(k));
        k++;
      end
    end

    $display("[TB] test 4: early exit on empty advances the pointer");
    doReset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) begin
        loadLane(0, 1, 2, 8'h90);
        applyStimulus(1'b1, 1'b0);
      end
      if (c == 1) begin
        loadLane(0, 0, 2, 8'h50);
        loadLane(0, 3, 2, 8'h70);
      end
      #1;
      case (c)
        1: begin
          checkOutput("t4_grant_c1", {6'b0, grant_a}, 8'h01);
          checkOutput("t4_pop_c1", {4'b0, pop_a}, 8'h02);
        end
        2: checkOutput("t4_pop_c2", {4'b0, pop_a}, 8'h02);
        3: begin
          checkOutput("t4_pop_c3", {4'b0, pop_a}, 8'h00);
          checkOutput("t4_active_c3", {7'b0, active_a}, 8'h01);
          checkOutput("t4_valid_c3", {7'b0, valid_a}, 8'h01);
          checkOutput("t4_data_c3", data_out_a, 8'h90);
        end
        4: begin
          checkOutput("t4_active_c4", {7'b0, active_a}, 8'h00);
          checkOutput("t4_data_c4", data_out_a, 8'h91);
        end
        5: begin
          checkOutput("t4_grant_c5", {6'b0, grant_a}, 8'h03);
          checkOutput("t4_pop_c5", {4'b0, pop_a}, 8'h08);
          checkOutput("t4_valid_c5", {7'b0, valid_a}, 8'h00);
        end
        7: checkOutput("t4_data_c7", data_out_a, 8'h70);
        9: begin
          checkOutput("t4_grant_c9", {6'b0, grant_a}, 8'h00);
          checkOutput("t4_pop_c9", {4'b0, pop_a}, 8'h01);
        end
        default: ;
      endcase
    end

    $display("[TB] test 5: reset mid-burst");
    doReset();
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c == 0) begin
        loadLane(0, 3, 4, 8'hE0);
        applyStimulus(1'b1, 1'b0);
      end
      if (c == 2) begin
        reset = 1'b0;
        loadLane(0, 1, 4, 8'hB0);
      end
      if (c == 4) reset = 1'b1;
      #1;
      case (c)
        1: checkOutput("t5_pop_c1", {4'b0, pop_a}, 8'h08);
        2: begin
          checkOutput("t5_pop_rst", {4'b0, pop_a}, 8'h00);
          checkOutput("t5_active_rst", {7'b0, active_a}, 8'h00);
          checkOutput("t5_grant_rst", {6'b0, grant_a}, 8'h00);
          checkOutput("t5_valid_rst", {7'b0, valid_a}, 8'h00);
          checkOutput("t5_data_rst", data_out_a, 8'h00);
        end
        3, 4, 6: checkOutput($sformatf("t5_valid_c%0d", c), {7'b0, valid_a}, 8'h00);
        5: begin
          checkOutput("t5_grant_c5", {6'b0, grant_a}, 8'h01);
          checkOutput("t5_pop_c5", {4'b0, pop_a}, 8'h02);
          checkOutput("t5_valid_c5", {7'b0, valid_a}, 8'h00);
        end
        7: begin
          checkOutput("t5_valid_c7", {7'b0, valid_a}, 8'h01);
          checkOutput("t5_data_c7", data_out_a, 8'hB0);
        end
        default: ;
      endcase
    end

    $display("[TB] test 6: enable dropped mid-burst");
    doReset();
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      if (c == 0) begin
        loadLane(0, 0, 6, 8'hD0);
        applyStimulus(1'b1, 1'b0);
      end
      if (c == 3) applyStimulus(1'b0, 1'b0);
      if (c == 7) applyStimulus(1'b1, 1'b0);
      #1;
      case (c)
        3: begin
          checkOutput("t6_pop_c3", {4'b0, pop_a}, 8'h00);
          checkOutput("t6_active_c3", {7'b0, active_a}, 8'h01);
          checkOutput("t6_data_c3", data_out_a, 8'hD0);
        end
        4: begin
          checkOutput("t6_active_c4", {7'b0, active_a}, 8'h00);
          checkOutput("t6_valid_c4", {7'b0, valid_a}, 8'h01);
          checkOutput("t6_data_c4", data_out_a, 8'hD1);
        end
        5: checkOutput("t6_valid_c5", {7'b0, valid_a}, 8'h00);
        6: begin
          checkOutput("t6_active_c6", {7'b0, active_a}, 8'h00);
          checkOutput("t6_pop_c6", {4'b0, pop_a}, 8'h00);
        end
        8: begin
          checkOutput("t6_grant_c8", {6'b0, grant_a}, 8'h00);
          checkOutput("t6_pop_c8", {4'b0, pop_a}, 8'h01);
        end
        10: begin
          checkOutput("t6_valid_c10", {7'b0, valid_a}, 8'h01);
          checkOutput("t6_data_c10", data_out_a, 8'hD2);
        end
        default: ;
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
